// File: rtl/fastram_block_mover_pkg.sv
// Shared types and constants for the fast RAM block mover.
// Block geometry and operating modes live here.
package fastram_block_mover_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int ADDR_W          = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    // Pointers wrap modulo 2^16.
    function automatic addr_t next_block(input addr_t a);
        return a + addr_t'(WORDS_PER_BLOCK);
    endfunction

endpackage

// File: rtl/fastram_block_mover_if.sv
// Bus between the block mover and one 4-word-wide fast RAM.
// The mover is the master; the RAM answers as slave.
interface fastram_block_mover_if
    import fastram_block_mover_pkg::*;
#(
    parameter int BIT_WIDTH = 16
);

    logic                 ram_load;
    logic                 ram_save;
    addr_t                ram_address;
    logic [BIT_WIDTH-1:0] ram_in0;
    logic [BIT_WIDTH-1:0] ram_in1;
    logic [BIT_WIDTH-1:0] ram_in2;
    logic [BIT_WIDTH-1:0] ram_in3;
    logic [BIT_WIDTH-1:0] ram_out0;
    logic [BIT_WIDTH-1:0] ram_out1;
    logic [BIT_WIDTH-1:0] ram_out2;
    logic [BIT_WIDTH-1:0] ram_out3;

    modport master (
        output ram_load, ram_save, ram_address,
        output ram_in0, ram_in1, ram_in2, ram_in3,
        input  ram_out0, ram_out1, ram_out2, ram_out3
    );

    modport slave (
        input  ram_load, ram_save, ram_address,
        input  ram_in0, ram_in1, ram_in2, ram_in3,
        output ram_out0, ram_out1, ram_out2, ram_out3
    );

endinterface

// File: rtl/fastram_block_mover.sv
// Block copy / block fill engine driving a 4-word-wide fast RAM.
// Copy costs READ, CAPTURE, WRITE per block; fill writes back to back.
module fastram_block_mover
    import fastram_block_mover_pkg::*;
#(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  addr_t                src_addr,
    input  addr_t                dst_addr,
    input  logic [15:0]          blocks,
    input  logic [BIT_WIDTH-1:0] fill_value,
    output logic                 busy,
    output logic                 done,
    fastram_block_mover_if.master ram
);

    typedef logic [3:0][BIT_WIDTH-1:0] lanes_t;

    state_t               state, state_d;
    addr_t                src_cur, src_nxt;
    addr_t                dst_cur, dst_nxt;
    logic [15:0]          rem_cur, rem_nxt;
    logic                 mode_cur, mode_nxt;
    logic [BIT_WIDTH-1:0] fill_cur, fill_nxt;
    lanes_t               cap_q, cap_nxt;

    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   load_q, load_d;
    logic   save_q, save_d;
    addr_t  addr_q, addr_d;
    lanes_t lane_q, lane_d;

    logic accept;
    logic last;

    assign accept = (state == IDLE) && start;
    assign last   = (rem_cur == 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (blocks == 16'd0)
                        state_d = DONE;
                    else if (mode == MODE_COPY)
                        state_d = READ;
                    else
                        state_d = WRITE;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = WRITE;
            WRITE: begin
                if (last)
                    state_d = DONE;
                else if (mode_cur == MODE_FILL)
                    state_d = WRITE;
                else
                    state_d = READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the operand/pointer registers.
    always_comb begin
        src_nxt  = src_cur;
        dst_nxt  = dst_cur;
        rem_nxt  = rem_cur;
        mode_nxt = mode_cur;
        fill_nxt = fill_cur;
        cap_nxt  = cap_q;
        if (accept) begin
            src_nxt  = src_addr;
            dst_nxt  = dst_addr;
            rem_nxt  = blocks;
            mode_nxt = mode;
            fill_nxt = fill_value;
        end
        if (state == CAPTURE) begin
            cap_nxt = {ram.ram_out3, ram.ram_out2,
                       ram.ram_out1, ram.ram_out0};
        end
        if (state == WRITE) begin
            src_nxt = next_block(src_cur);
            dst_nxt = next_block(dst_cur);
            rem_nxt = rem_cur - 16'd1;
        end
    end

    // Outputs are decoded from the state being entered, then registered.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        load_d = (state_d == READ);
        save_d = (state_d == WRITE);
        addr_d = addr_q;
        lane_d = lane_q;
        if (load_d) begin
            addr_d = src_nxt;
        end
        if (save_d) begin
            addr_d = dst_nxt;
            if (mode_nxt == MODE_FILL)
                lane_d = {4{fill_nxt}};
            else
                lane_d = cap_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_cur  <= '0;
            dst_cur  <= '0;
            rem_cur  <= '0;
            mode_cur <= MODE_COPY;
            fill_cur <= '0;
            cap_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            save_q   <= 1'b0;
            addr_q   <= '0;
            lane_q   <= '0;
        end else begin
            src_cur  <= src_nxt;
            dst_cur  <= dst_nxt;
            rem_cur  <= rem_nxt;
            mode_cur <= mode_nxt;
            fill_cur <= fill_nxt;
            cap_q    <= cap_nxt;
            busy_q   <= busy_d;
            done_q   <= done_d;
            load_q   <= load_d;
            save_q   <= save_d;
            addr_q   <= addr_d;
            lane_q   <= lane_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign ram.ram_load    = load_q;
    assign ram.ram_save    = save_q;
    assign ram.ram_address = addr_q;
    assign ram.ram_in0     = lane_q[0];
    assign ram.ram_in1     = lane_q[1];
    assign ram.ram_in2     = lane_q[2];
    assign ram.ram_in3     = lane_q[3];

endmodule

// File: tb/tb_fastram_block_mover.sv
// Bench for the block mover: fast RAM responder plus a word-level
// reference memory updated block by block in ascending order.
module tb_fastram_block_mover;
    import fastram_block_mover_pkg::*;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [15:0]   src_addr = '0;
    logic [15:0]   dst_addr = '0;
    logic [15:0]   blocks = '0;
    logic [BW-1:0] fill_value = '0;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fastram_block_mover_if #(.BIT_WIDTH(BW)) rif ();

    fastram_block_mover #(.BIT_WIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .blocks     (blocks),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .ram        (rif)
    );

    // Fast RAM responder
    logic [BW-1:0] mem [0:65535];
    logic [BW-1:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;
    logic          oe = 1'b0;
    logic          init_req = 1'b0;
    logic [15:0]   seed = '0;
    logic          bd_req = 1'b0;
    logic [15:0]   bd_addr = '0;
    logic [BW-1:0] bd_data = '0;

    function automatic logic [15:0] pat(input logic [15:0] a,
                                        input logic [15:0] s);
        return (a * 16'h9E37) ^ s ^ {a[7:0], a[15:8]};
    endfunction

    always @(posedge clk) begin
        oe <= rif.ram_load;
        if (rif.ram_load) begin
            q0 <= mem[rif.ram_address];
            q1 <= mem[rif.ram_address + 16'd1];
            q2 <= mem[rif.ram_address + 16'd2];
            q3 <= mem[rif.ram_address + 16'd3];
        end
    end

    assign rif.ram_out0 = oe ? q0 : 'z;
    assign rif.ram_out1 = oe ? q1 : 'z;
    assign rif.ram_out2 = oe ? q2 : 'z;
    assign rif.ram_out3 = oe ? q3 : 'z;

    always @(negedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 65536; i++)
                mem[i[15:0]] <= pat(i[15:0], seed);
        end else if (bd_req) begin
            mem[bd_addr] <= bd_data;
        end else if (rif.ram_save) begin
            mem[rif.ram_address]         <= rif.ram_in0;
            mem[rif.ram_address + 16'd1] <= rif.ram_in1;
            mem[rif.ram_address + 16'd2] <= rif.ram_in2;
            mem[rif.ram_address + 16'd3] <= rif.ram_in3;
        end
    end

    // Strobe log: every load/save seen at the write edge
    int          lg_n = 0;
    int          both_hi = 0;
    logic [15:0] lg_a [0:1023];
    logic        lg_s [0:1023];

    always @(negedge clk) begin
        if (rif.ram_load || rif.ram_save) begin
            if (lg_n < 1024) begin
                lg_a[lg_n] <= rif.ram_address;
                lg_s[lg_n] <= rif.ram_save;
            end
            lg_n <= lg_n + 1;
        end
        if (rif.ram_load && rif.ram_save)
            both_hi <= both_hi + 1;
    end

    // Reference memory
    logic [15:0] rm [0:65535];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_init(input logic [15:0] s);
        for (int i = 0; i < 65536; i++)
            rm[i[15:0]] = pat(i[15:0], s);
    endtask

    task automatic model_op(input logic m, input logic [15:0] s,
                            input logic [15:0] d, input int nb,
                            input logic [15:0] fv);
        logic [15:0] tmp [4];
        logic [15:0] a;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 4; i++) begin
                a = s + 16'(4 * b + i);
                tmp[i] = (m == MODE_FILL) ? fv : rm[a];
            end
            for (int i = 0; i < 4; i++) begin
                a = d + 16'(4 * b + i);
                rm[a] = tmp[i];
            end
        end
    endtask

    task automatic mem_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i[15:0]] !== rm[i[15:0]]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [15:0] v);
        bd_addr = a;
        bd_data = v;
        bd_req  = 1'b1;
        @(negedge clk);
        #1;
        bd_req  = 1'b0;
        rm[a]   = v;
    endtask

    task automatic run_op(input string tag, input logic m,
                          input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] nb, input logic [15:0] fv,
                          input bit poke);
        int k, base, e, bad, bound, exp_k, idx;
        bit busy_ok;
        @(negedge clk);
        #1;
        base       = lg_n;
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        blocks     = nb;
        fill_value = fv;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        mode       = 1'($urandom);
        src_addr   = 16'($urandom);
        dst_addr   = 16'($urandom);
        blocks     = 16'($urandom);
        fill_value = 16'($urandom);
        k = 0;
        busy_ok = 1'b1;
        bound = 3 * int'(nb) + 10;
        while (!done && k < bound) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && k == 2) begin
                start    = 1'b1;
                mode     = ~m;
                src_addr = 16'($urandom);
                dst_addr = 16'($urandom);
                blocks   = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        if (!busy) busy_ok = 1'b0;
        exp_k = int'(nb) * ((m == MODE_FILL) ? 1 : 3);
        check({tag, "_done_latency"}, k, exp_k);
        check({tag, "_busy_held"}, 32'(busy_ok), 1);
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, 32'(done), 0);
        check({tag, "_busy_drop"}, 32'(busy), 0);
        e = 0;
        bad = 0;
        for (int b = 0; b < int'(nb); b++) begin
            if (m == MODE_COPY) begin
                idx = base + e;
                if (idx >= 1024 || idx >= lg_n || lg_s[idx] !== 1'b0 ||
                    lg_a[idx] !== s + 16'(4 * b)) bad++;
                e++;
            end
            idx = base + e;
            if (idx >= 1024 || idx >= lg_n || lg_s[idx] !== 1'b1 ||
                lg_a[idx] !== d + 16'(4 * b)) bad++;
            e++;
        end
        check({tag, "_strobe_count"}, lg_n - base, e);
        check({tag, "_strobe_seq"}, bad, 0);
        model_op(m, s, d, int'(nb), fv);
        mem_check({tag, "_mem"});
    endtask

    initial begin
        int          k, nsave, seen;
        bit          hit;
        logic [15:0] s, d, nb;
        logic        m;

        // Reset held while start toggles
        seed = 16'($urandom);
        init_req = 1'b1;
        @(negedge clk);
        #1;
        init_req = 1'b0;
        model_init(seed);
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            mode  = 1'b1;
            blocks = 16'd1;
            @(posedge clk);
            #1;
        end
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_load", 32'(rif.ram_load), 0);
        check("rst_save", 32'(rif.ram_save), 0);
        check("rst_addr", 32'(rif.ram_address), 0);
        check("rst_lanes", {rif.ram_in0 | rif.ram_in1,
                            rif.ram_in2 | rif.ram_in3}, 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_busy", 32'(busy), 0);
        check("rel_load", 32'(rif.ram_load), 0);

        // Directed copy of two blocks
        for (int i = 0; i < 8; i++)
            bd_write(16'h0010 + 16'(i), 16'hA000 + 16'(i));
        run_op("copy2", MODE_COPY, 16'h0010, 16'h0100, 16'd2, 16'h0, 1'b0);
        check("copy2_last_word", 32'(mem[16'h0107]), 32'h0000A007);

        // Fill of three blocks, neighbour untouched
        run_op("fill3", MODE_FILL, 16'h0, 16'h0200, 16'd3, 16'h5A5A, 1'b0);
        check("fill3_end_word", 32'(mem[16'h020B]), 32'h00005A5A);
        check("fill3_next_word", 32'(mem[16'h020C]),
              32'(pat(16'h020C, seed)));

        // Zero length and pointer wrap
        run_op("zero", MODE_COPY, 16'h1234, 16'h4321, 16'd0, 16'h0, 1'b0);
        run_op("wrap", MODE_FILL, 16'h0, 16'hFFFC, 16'd2, 16'hC3C3, 1'b0);

        // Start re-asserted mid-copy
        run_op("poke", MODE_COPY, 16'h3000, 16'h3100, 16'd2, 16'h0, 1'b1);

        // Reset during the second block's write of a 4-block copy
        s = 16'h4000;
        d = 16'h5000;
        @(negedge clk);
        #1;
        mode     = MODE_COPY;
        src_addr = s;
        dst_addr = d;
        blocks   = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nsave = 0;
        k = 0;
        hit = 1'b0;
        while (!hit && k < 30) begin
            if (rif.ram_save) nsave++;
            if (nsave == 2) begin
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        rst = 1'b0;
        #1;
        check("midrst_reached", 32'(hit), 1);
        check("midrst_save", 32'(rif.ram_save), 0);
        check("midrst_busy", 32'(busy), 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("midrst_quiet", seen, 0);
        @(negedge clk);
        rst = 1'b1;
        model_op(MODE_COPY, s, d, 1, 16'h0);
        mem_check("midrst_mem");
        run_op("after_rst", MODE_COPY, 16'h6000, 16'h6040, 16'd3, 16'h0,
               1'b0);

        // Randomised operations
        for (int n = 0; n < 8; n++) begin
            m  = 1'($urandom);
            s  = 16'($urandom);
            d  = 16'($urandom);
            nb = 16'($urandom_range(1, 5));
            run_op($sformatf("rand%0d", n), m, s, d, nb, 16'($urandom),
                   1'b0);
        end

        check("load_save_exclusive", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
